mult_div_unit: RTL

Multi-cycle signed multiply/divide responder. It executes MULT and DIV for the multicycle MIPS control FSM. The controller raises mult_op or div_op and waits for done. The unit then writes HI/LO results, with lo = product low word or quotient, and hi = product high word or remainder.

---
 rtl/mult_div_pkg.sv | 14 +
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the multi-cycle signed multiply/divide unit.
package mult_div_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W = $clog2(WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MULT_RUN = 2'b01,
    DIV_RUN  = 2'b10,
    FINISH   = 2'b11
  } state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply/divide unit producing MIPS HI/LO results.
// Magnitudes are processed one bit per clock (shift-add multiply or
// restoring divide) in a shared 2*WIDTH working register; sign correction
// is applied once, when the results are written.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mult_op,
  input  logic             div_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_BITS = (WIDTH == WIDTH_DEFAULT) ? CNT_W : $clog2(WIDTH);
  localparam logic [CNT_BITS-1:0] LAST_ITER = CNT_BITS'(WIDTH - 1);

  // Magnitude of a two's-complement value; the most negative value maps to
  // its unsigned magnitude (e.g. 0x80000000 stays 0x80000000).
  function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  // Conditional two's-complement negation, single word.
  function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Conditional two's-complement negation, double word (full product).
  function automatic logic [2*WIDTH-1:0] neg_dword(input logic [2*WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t              state;
  state_t              next_state;
  logic [CNT_BITS-1:0] counter;
  // Multiply: {partial product high, multiplier shifting out / product low}.
  // Divide:   {remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0]  work;
  logic [WIDTH-1:0]    operand;   // |multiplicand| or |divisor|
  logic                is_div;
  logic                neg_res;   // product / quotient sign
  logic                neg_rem;   // remainder follows the dividend sign
  logic                start;
  logic                zero_div;
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH:0]      div_shift;
  logic                div_fit;
  logic [WIDTH-1:0]    div_sub;
  logic [2*WIDTH-1:0]  prod_signed;

  assign start    = mult_op | div_op;
  assign zero_div = div_op & ~mult_op & (op_b == '0);
  assign busy     = (state != IDLE);

  // Per-iteration arithmetic for both algorithms and the final product sign fix
  always_comb begin
    mul_sum     = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, (work[0] ? operand : '0)};
    div_shift   = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    div_fit     = (div_shift >= {1'b0, operand});
    div_sub     = div_shift[WIDTH-1:0] - operand;
    prod_signed = neg_dword(work, neg_res);
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; multiply wins when both starts are raised together
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (mult_op)     next_state = MULT_RUN;
        else if (div_op) next_state = (op_b == '0) ? FINISH : DIV_RUN;
      end
      MULT_RUN: if (counter == LAST_ITER) next_state = FINISH;
      DIV_RUN:  if (counter == LAST_ITER) next_state = FINISH;
      FINISH:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and HI/LO write-back
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter  <= '0;
      work     <= '0;
      operand  <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            counter  <= '0;
            div_zero <= zero_div;
            neg_res  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_rem  <= op_a[WIDTH-1];
            if (mult_op) begin
              is_div  <= 1'b0;
              operand <= abs_mag(op_a);
              work    <= {{WIDTH{1'b0}}, abs_mag(op_b)};
            end else begin
              is_div  <= 1'b1;
              operand <= abs_mag(op_b);
              work    <= {{WIDTH{1'b0}}, abs_mag(op_a)};
            end
          end
        end
        MULT_RUN: begin
          work    <= {mul_sum, work[WIDTH-1:1]};
          counter <= counter + 1'b1;
        end
        DIV_RUN: begin
          work    <= {(div_fit ? div_sub : div_shift[WIDTH-1:0]), work[WIDTH-2:0], div_fit};
          counter <= counter + 1'b1;
        end
        FINISH: begin
          // A zero divisor leaves the previous HI/LO visible
          if (!div_zero) begin
            if (is_div) begin
              lo_out <= neg_word(work[WIDTH-1:0], neg_res);
              hi_out <= neg_word(work[2*WIDTH-1:WIDTH], neg_rem);
            end else begin
              hi_out <= prod_signed[2*WIDTH-1:WIDTH];
              lo_out <= prod_signed[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
